// File: rtl/axi_traffic_gen.sv
// axi_traffic_gen: AXI4 master that writes NUM_BURSTS incrementing bursts of
// an address-derived pattern, then reads the region back and counts mismatches.
// Channel handshake: a valid rises independently of its ready and holds, with a
// stable payload, until the clock edge where valid and ready are both high.
// Only one channel is active at a time and no transaction is ever outstanding.
module axi_traffic_gen #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int BURST_LEN  = 4,
   parameter int NUM_BURSTS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   output logic [ADDR_W-1:0]     awaddr,
   output logic [7:0]            awlen,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   output logic [ADDR_W-1:0]     araddr,
   output logic [7:0]            arlen,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_W-1:0]     rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           err_count
);

   localparam int              LANES      = DATA_W / 32;
   localparam logic [ADDR_W-1:0] BEAT_INC  = ADDR_W'(DATA_W / 8);
   localparam logic [ADDR_W-1:0] BURST_INC = ADDR_W'(BURST_LEN * (DATA_W / 8));
   localparam logic [7:0]      LAST_BEAT  = 8'(BURST_LEN - 1);
   localparam logic [15:0]     LAST_BURST = 16'(NUM_BURSTS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   base_q;        // run start address
   logic [ADDR_W-1:0]   burst_addr_q;  // address of the current burst
   logic [ADDR_W-1:0]   beat_addr_q;   // byte address of the current beat
   logic [15:0]         burst_q;
   logic [7:0]          beat_q;
   logic [15:0]         err_q;
   logic [DATA_W-1:0]   pattern;
   logic                last_beat, last_burst, err_inc;

   assign last_beat  = (beat_q == LAST_BEAT);
   assign last_burst = (burst_q == LAST_BURST);

   // Expected data for the current beat: every 32-bit lane carries the address pattern
   always_comb begin
      pattern = '0;
      for (int l = 0; l < LANES; l++) begin
         pattern[l*32 +: 32] = 32'(beat_addr_q) ^ 32'hA5A5_5A5A;
      end
   end

   // One error per bad write response or per bad read beat
   always_comb begin
      err_inc = 1'b0;
      if (state_q == S_WR_RESP && bvalid && bresp != 2'b00) begin
         err_inc = 1'b1;
      end
      if (state_q == S_RD_DATA && rvalid &&
          (rresp != 2'b00 || rdata != pattern || rlast != last_beat)) begin
         err_inc = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: advance on each channel's handshake
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (start)               state_d = S_WR_ADDR;
         S_WR_ADDR: if (awready)             state_d = S_WR_DATA;
         S_WR_DATA: if (wready && last_beat) state_d = S_WR_RESP;
         S_WR_RESP: if (bvalid)              state_d = last_burst ? S_RD_ADDR : S_WR_ADDR;
         S_RD_ADDR: if (arready)             state_d = S_RD_DATA;
         S_RD_DATA: if (rvalid && last_beat) state_d = last_burst ? S_DONE : S_RD_ADDR;
         S_DONE:                             state_d = S_IDLE;
         default:                            state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      awvalid = (state_q == S_WR_ADDR);
      wvalid  = (state_q == S_WR_DATA);
      wlast   = (state_q == S_WR_DATA) && last_beat;
      wdata   = (state_q == S_WR_DATA) ? pattern : '0;
      bready  = (state_q == S_WR_RESP);
      arvalid = (state_q == S_RD_ADDR);
      rready  = (state_q == S_RD_DATA);
      busy    = (state_q != S_IDLE);
      done    = (state_q == S_DONE);
   end

   assign awaddr    = burst_addr_q;
   assign araddr    = burst_addr_q;
   assign awlen     = LAST_BEAT;
   assign arlen     = LAST_BEAT;
   assign wstrb     = '1;
   assign err_count = err_q;

   // Address/beat/burst counters and the saturating error counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q       <= '0;
         burst_addr_q <= '0;
         beat_addr_q  <= '0;
         burst_q      <= '0;
         beat_q       <= '0;
         err_q        <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: if (start) begin
               base_q       <= base_addr;
               burst_addr_q <= base_addr;
               burst_q      <= '0;
               err_q        <= '0;
            end
            S_WR_ADDR, S_RD_ADDR: if ((state_q == S_WR_ADDR) ? awready : arready) begin
               beat_q      <= '0;
               beat_addr_q <= burst_addr_q;
            end
            S_WR_DATA: if (wready) begin
               beat_q      <= beat_q + 8'd1;
               beat_addr_q <= beat_addr_q + BEAT_INC;
            end
            S_WR_RESP: if (bvalid) begin
               // After the last write burst, rewind to the base for the read pass
               if (last_burst) begin
                  burst_q      <= '0;
                  burst_addr_q <= base_q;
               end else begin
                  burst_q      <= burst_q + 16'd1;
                  burst_addr_q <= burst_addr_q + BURST_INC;
               end
            end
            S_RD_DATA: if (rvalid) begin
               beat_q      <= beat_q + 8'd1;
               beat_addr_q <= beat_addr_q + BEAT_INC;
               if (last_beat && !last_burst) begin
                  burst_q      <= burst_q + 16'd1;
                  burst_addr_q <= burst_addr_q + BURST_INC;
               end
            end
            default: ;
         endcase
         if (err_inc && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
         end
      end
   end

endmodule
